// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI burst/response encodings, FSM states and burst address stepping.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WDATA,
      ST_WRESP,
      ST_RDATA
   } state_t;

   // Reserved burst type, or a WRAP whose beat count is not 2/4/8/16.
   function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
      logic bad;
      bad = 1'b0;
      if (burst == 2'b11) begin
         bad = 1'b1;
      end else if (burst == BURST_WRAP) begin
         bad = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
      end
      return bad;
   endfunction

   // Transfers are always 4 bytes; a WRAP window is (len+1)*4 bytes.
   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [1:0] burst);
      logic [31:0] mask;
      logic [31:0] nxt;
      mask = {22'd0, len, 2'b11};
      case (burst)
         BURST_FIXED: nxt = addr;
         BURST_WRAP:  nxt = (addr & ~mask) | ((addr + 32'd4) & mask);
         default:     nxt = addr + 32'd4;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/axi_burst_ram.sv
// rtl/axi_burst_ram.sv - single-port byte-enabled 32-bit RAM with a registered read port.
module axi_burst_ram #(
   parameter int WORDS = 256,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [3:0]       i_wstrb,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata
);

   logic [31:0] r_mem [WORDS];

   // Memory array is deliberately not reset so contents survive ARESET.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wstrb[b]) begin
               r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_rdata <= 32'd0;
      end else begin
         o_rdata <= r_mem[i_idx];
      end
   end

endmodule

// File: rtl/axi4_burst_responder.sv
// rtl/axi4_burst_responder.sv - AXI4 slave answering one FIXED/INCR/WRAP burst at a time from an internal RAM.
module axi4_burst_responder
   import axi_pkg::*;
#(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_MEM_WORDS        = 256
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [7:0]                    S_AXI_AWLEN,
   input  logic [1:0]                    S_AXI_AWBURST,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [31:0]                   S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WLAST,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [7:0]                    S_AXI_ARLEN,
   input  logic [1:0]                    S_AXI_ARBURST,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
   output logic [31:0]                   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RLAST,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY
);

   localparam int IDX_W = $clog2(C_MEM_WORDS);

   state_t                      r_state;
   state_t                      w_next;
   logic [C_S_AXI_ID_WIDTH-1:0] r_id;
   logic [31:0]                 r_addr;
   logic [7:0]                  r_len;
   logic [7:0]                  r_cnt;
   logic [1:0]                  r_burst;
   logic [1:0]                  r_resp;

   logic             w_aw_hs;
   logic             w_ar_hs;
   logic             w_w_hs;
   logic             w_r_hs;
   logic             w_aw_bad;
   logic             w_ar_bad;
   logic             w_last_beat;
   logic [31:0]      w_aw_addr;
   logic [31:0]      w_ar_addr;
   logic [31:0]      w_next_addr;
   logic [IDX_W-1:0] w_ram_idx;
   logic [31:0]      w_ram_rdata;

   assign w_aw_addr   = 32'(S_AXI_AWADDR);
   assign w_ar_addr   = 32'(S_AXI_ARADDR);
   assign w_aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
   assign w_w_hs      = S_AXI_WVALID && S_AXI_WREADY;
   assign w_r_hs      = S_AXI_RVALID && S_AXI_RREADY;
   assign w_aw_bad    = burst_illegal(S_AXI_AWBURST, S_AXI_AWLEN);
   assign w_ar_bad    = burst_illegal(S_AXI_ARBURST, S_AXI_ARLEN);
   assign w_last_beat = (r_cnt == r_len);
   assign w_next_addr = next_addr(r_addr, r_len, r_burst);

   // The RAM read register is one beat ahead: in IDLE it fetches the AR start word,
   // and during a read it fetches the following word on each R handshake.
   always_comb begin
      w_ram_idx = r_addr[IDX_W+1:2];
      if (r_state == ST_IDLE) begin
         w_ram_idx = w_ar_addr[IDX_W+1:2];
      end else if (w_r_hs) begin
         w_ram_idx = w_next_addr[IDX_W+1:2];
      end
   end

   axi_burst_ram #(
      .WORDS (C_MEM_WORDS),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk     (ACLK),
      .rst     (ARESET),
      .i_we    (w_w_hs),
      .i_wstrb (S_AXI_WSTRB),
      .i_idx   (w_ram_idx),
      .i_wdata (S_AXI_WDATA),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      S_AXI_AWREADY = 1'b0;
      S_AXI_ARREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      S_AXI_RVALID  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Write has priority when both address channels are valid together.
            S_AXI_AWREADY = !ARESET;
            S_AXI_ARREADY = !ARESET && !S_AXI_AWVALID;
            if (S_AXI_AWVALID && !ARESET) begin
               w_next = ST_WDATA;
            end else if (S_AXI_ARVALID && !ARESET) begin
               w_next = ST_RDATA;
            end
         end
         ST_WDATA: begin
            S_AXI_WREADY = 1'b1;
            if (S_AXI_WVALID && S_AXI_WLAST) begin
               w_next = ST_WRESP;
            end
         end
         ST_WRESP: begin
            S_AXI_BVALID = 1'b1;
            if (S_AXI_BREADY) begin
               w_next = ST_IDLE;
            end
         end
         ST_RDATA: begin
            S_AXI_RVALID = 1'b1;
            if (S_AXI_RREADY && w_last_beat) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_id    <= '0;
         r_addr  <= 32'd0;
         r_len   <= 8'd0;
         r_cnt   <= 8'd0;
         r_burst <= BURST_INCR;
         r_resp  <= RESP_OKAY;
      end else if (w_aw_hs) begin
         r_id    <= S_AXI_AWID;
         r_addr  <= w_aw_addr;
         r_len   <= S_AXI_AWLEN;
         r_cnt   <= 8'd0;
         r_burst <= w_aw_bad ? BURST_INCR : S_AXI_AWBURST;
         r_resp  <= w_aw_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (w_ar_hs) begin
         r_id    <= S_AXI_ARID;
         r_addr  <= w_ar_addr;
         r_len   <= S_AXI_ARLEN;
         r_cnt   <= 8'd0;
         r_burst <= w_ar_bad ? BURST_INCR : S_AXI_ARBURST;
         r_resp  <= w_ar_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (w_w_hs) begin
         r_addr <= w_next_addr;
         r_cnt  <= r_cnt + 8'd1;
         // A WLAST/length disagreement poisons the response but every beat is still stored.
         if (S_AXI_WLAST != w_last_beat) begin
            r_resp <= RESP_SLVERR;
         end
      end else if (w_r_hs) begin
         r_addr <= w_next_addr;
         r_cnt  <= r_cnt + 8'd1;
      end
   end

   assign S_AXI_BID   = r_id;
   assign S_AXI_BRESP = (r_state == ST_WRESP) ? r_resp : RESP_OKAY;
   assign S_AXI_RID   = r_id;
   assign S_AXI_RRESP = (r_state == ST_RDATA) ? r_resp : RESP_OKAY;
   assign S_AXI_RDATA = (r_state == ST_RDATA) ? w_ram_rdata : 32'd0;
   assign S_AXI_RLAST = (r_state == ST_RDATA) && w_last_beat;

endmodule

// File: tb/tb_axi4_burst_responder.sv
// tb/tb_axi4_burst_responder.sv - directed self-checking bench for axi4_burst_responder.
`timescale 1ns/1ps
module tb_axi4_burst_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [0:0]  AWID = '0;
   logic [31:0] AWADDR = '0;
   logic [7:0]  AWLEN = '0;
   logic [1:0]  AWBURST = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WLAST = 1'b0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [0:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [0:0]  ARID = '0;
   logic [31:0] ARADDR = '0;
   logic [7:0]  ARLEN = '0;
   logic [1:0]  ARBURST = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [0:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY = 1'b0;

   always #5 clk = ~clk;

   axi4_burst_responder #(
      .C_S_AXI_ID_WIDTH   (1),
      .C_S_AXI_ADDR_WIDTH (32),
      .C_MEM_WORDS        (256)
   ) dut (
      .ACLK          (clk),
      .ARESET        (rst),
      .S_AXI_AWID    (AWID),
      .S_AXI_AWADDR  (AWADDR),
      .S_AXI_AWLEN   (AWLEN),
      .S_AXI_AWBURST (AWBURST),
      .S_AXI_AWVALID (AWVALID),
      .S_AXI_AWREADY (AWREADY),
      .S_AXI_WDATA   (WDATA),
      .S_AXI_WSTRB   (WSTRB),
      .S_AXI_WLAST   (WLAST),
      .S_AXI_WVALID  (WVALID),
      .S_AXI_WREADY  (WREADY),
      .S_AXI_BID     (BID),
      .S_AXI_BRESP   (BRESP),
      .S_AXI_BVALID  (BVALID),
      .S_AXI_BREADY  (BREADY),
      .S_AXI_ARID    (ARID),
      .S_AXI_ARADDR  (ARADDR),
      .S_AXI_ARLEN   (ARLEN),
      .S_AXI_ARBURST (ARBURST),
      .S_AXI_ARVALID (ARVALID),
      .S_AXI_ARREADY (ARREADY),
      .S_AXI_RID     (RID),
      .S_AXI_RDATA   (RDATA),
      .S_AXI_RRESP   (RRESP),
      .S_AXI_RLAST   (RLAST),
      .S_AXI_RVALID  (RVALID),
      .S_AXI_RREADY  (RREADY)
   );

   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] wr_data [16];
   logic [31:0] rd_data [16];
   logic [15:0] rd_last;
   logic [31:0] rd_resp;
   logic [0:0]  rd_id;
   int          rd_n;
   int          rd_first_wait;
   int          rd_cycles;
   int          stall_err;
   bit          timeout;
   logic        g_ar_at_aw;
   logic [0:0]  g_bid;
   logic [1:0]  g_bresp;

   function automatic logic [31:0] pat_word(input int i);
      return 32'hFFFF_FFFF - 32'(i) * 32'h1111_1111;
   endfunction

   task automatic aw_phase(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
      bit done = 1'b0;
      AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (AWREADY) begin
            done = 1'b1;
            g_ar_at_aw = ARREADY;
         end
         @(posedge clk); #1;
      end
      if (!done) timeout = 1'b1;
      AWVALID = 1'b0;
   endtask

   task automatic ar_phase(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
      bit done = 1'b0;
      ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (ARREADY) done = 1'b1;
         @(posedge clk); #1;
      end
      if (!done) timeout = 1'b1;
      ARVALID = 1'b0;
   endtask

   task automatic w_phase(input int n, input int last_beat, input logic [3:0] strb);
      bit done;
      for (int i = 0; i < n; i++) begin
         WDATA = wr_data[i]; WSTRB = strb; WLAST = (i == last_beat); WVALID = 1'b1;
         done = 1'b0;
         for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (WREADY) done = 1'b1;
            @(posedge clk); #1;
         end
         if (!done) timeout = 1'b1;
      end
      WVALID = 1'b0; WLAST = 1'b0;
   endtask

   task automatic b_phase();
      bit done = 1'b0;
      BREADY = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (BVALID) begin
            done = 1'b1;
            g_bid = BID;
            g_bresp = BRESP;
         end
         @(posedge clk); #1;
      end
      if (!done) timeout = 1'b1;
      BREADY = 1'b0;
   endtask

   task automatic do_write(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int n, input int last_beat,
                           input logic [3:0] strb);
      aw_phase(id, addr, len, burst);
      w_phase(n, last_beat, strb);
      b_phase();
   endtask

   // Collects up to max_beats R beats; with stall set RREADY follows 1,0,0,1 per cycle.
   task automatic r_phase(input int max_beats, input bit stall);
      logic [3:0]  pat = 4'b1001;
      logic [34:0] held = '0;
      bit          held_v = 1'b0;
      rd_n = 0; rd_cycles = 0; rd_first_wait = -1; stall_err = 0;
      rd_last = '0; rd_resp = '0;
      for (int c = 0; c < 200 && rd_n < max_beats; c++) begin
         RREADY = stall ? pat[c % 4] : 1'b1;
         @(negedge clk);
         if (RVALID) begin
            if (rd_first_wait < 0) rd_first_wait = c;
            if (held_v && ({RDATA, RLAST, RRESP} !== held)) stall_err++;
            if (RREADY) begin
               rd_data[rd_n] = RDATA;
               rd_last[rd_n] = RLAST;
               rd_resp[2*rd_n +: 2] = RRESP;
               rd_id = RID;
               rd_n++;
               held_v = 1'b0;
            end else begin
               held = {RDATA, RLAST, RRESP};
               held_v = 1'b1;
            end
         end
         rd_cycles = c + 1;
         @(posedge clk); #1;
      end
      RREADY = 1'b0;
      if (rd_n < max_beats) timeout = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_total++;
      if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST} !== 6'b0)
         $display("FAIL reset_ctrl: got %b expected 000000", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST});
      else n_pass++;
      n_total++;
      if ({BRESP, RRESP, BID, RID, RDATA} !== 38'd0)
         $display("FAIL reset_data: got %h expected 0", {BRESP, RRESP, BID, RID, RDATA});
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({AWREADY, ARREADY} !== 2'b11)
         $display("FAIL idle_ready: got %b expected 11", {AWREADY, ARREADY});
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_incr();
      timeout = 1'b0;
      for (int i = 0; i < 16; i++) wr_data[i] = pat_word(i);
      do_write(1'b1, 32'h0, 8'd15, 2'b01, 16, 15, 4'hF);
      n_total++;
      if ({g_bid, g_bresp} !== 3'b100)
         $display("FAIL incr_b: got bid=%b bresp=%b expected bid=1 bresp=00", g_bid, g_bresp);
      else n_pass++;
      ar_phase(1'b0, 32'h0, 8'd15, 2'b01);
      r_phase(16, 1'b0);
      n_total++;
      if (timeout !== 1'b0) $display("FAIL incr_timeout: got %b expected 0", timeout);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_total++;
         if (rd_data[i] !== pat_word(i))
            $display("FAIL incr_data[%0d]: got %h expected %h", i, rd_data[i], pat_word(i));
         else n_pass++;
      end
      n_total++;
      if (rd_last !== 16'h8000) $display("FAIL incr_rlast: got %h expected 8000", rd_last);
      else n_pass++;
      n_total++;
      if ({rd_resp, rd_id} !== 33'd0) $display("FAIL incr_rresp_rid: got %h expected 0", {rd_resp, rd_id});
      else n_pass++;
      n_total++;
      if ({rd_first_wait, rd_cycles} !== {32'sd0, 32'sd16})
         $display("FAIL incr_timing: got first=%0d cycles=%0d expected first=0 cycles=16", rd_first_wait, rd_cycles);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int exp_idx [4] = '{10, 11, 8, 9};
      timeout = 1'b0;
      ar_phase(1'b1, 32'h28, 8'd3, 2'b10);
      r_phase(4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (rd_data[i] !== pat_word(exp_idx[i]))
            $display("FAIL wrap_data[%0d]: got %h expected %h", i, rd_data[i], pat_word(exp_idx[i]));
         else n_pass++;
      end
      n_total++;
      if ({timeout, rd_last[3:0], rd_resp[7:0], rd_id} !== {1'b0, 4'b1000, 8'd0, 1'b1})
         $display("FAIL wrap_ctrl: got to=%b last=%b resp=%h rid=%b expected 0 1000 00 1",
                  timeout, rd_last[3:0], rd_resp[7:0], rd_id);
      else n_pass++;
   endtask

   task automatic test_strobe();
      timeout = 1'b0;
      wr_data[0] = 32'h0;
      do_write(1'b0, 32'h40, 8'd0, 2'b01, 1, 0, 4'hF);
      wr_data[0] = 32'hAABBCCDD;
      do_write(1'b0, 32'h40, 8'd0, 2'b01, 1, 0, 4'b0101);
      ar_phase(1'b0, 32'h40, 8'd0, 2'b01);
      r_phase(1, 1'b0);
      n_total++;
      if (rd_data[0] !== 32'h00BB00DD) $display("FAIL strobe_data: got %h expected 00bb00dd", rd_data[0]);
      else n_pass++;
      wr_data[0] = 32'h0; wr_data[1] = 32'h0; wr_data[2] = 32'h0;
      do_write(1'b0, 32'h4C, 8'd2, 2'b01, 3, 2, 4'hF);
      wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222; wr_data[2] = 32'h33333333;
      do_write(1'b0, 32'h50, 8'd2, 2'b00, 3, 2, 4'hF);
      n_total++;
      if (g_bresp !== 2'b00) $display("FAIL fixed_bresp: got %b expected 00", g_bresp);
      else n_pass++;
      ar_phase(1'b0, 32'h4C, 8'd2, 2'b01);
      r_phase(3, 1'b0);
      n_total++;
      if ({timeout, rd_data[0], rd_data[1], rd_data[2]} !== {1'b0, 32'h0, 32'h33333333, 32'h0})
         $display("FAIL fixed_data: got to=%b %h %h %h expected 0 00000000 33333333 00000000",
                  timeout, rd_data[0], rd_data[1], rd_data[2]);
      else n_pass++;
   endtask

   task automatic test_slverr();
      timeout = 1'b0;
      wr_data[0] = 32'hA0A0A0A0; wr_data[1] = 32'hB1B1B1B1; wr_data[2] = 32'hC2C2C2C2;
      do_write(1'b1, 32'h80, 8'd3, 2'b01, 3, 2, 4'hF);
      n_total++;
      if ({g_bid, g_bresp} !== 3'b110)
         $display("FAIL early_wlast_b: got bid=%b bresp=%b expected bid=1 bresp=10", g_bid, g_bresp);
      else n_pass++;
      ar_phase(1'b0, 32'h80, 8'd2, 2'b01);
      r_phase(3, 1'b0);
      n_total++;
      if ({rd_data[0], rd_data[1], rd_data[2], rd_resp[5:0]} !== {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 6'd0})
         $display("FAIL early_wlast_ram: got %h %h %h resp=%h expected a0a0a0a0 b1b1b1b1 c2c2c2c2 00",
                  rd_data[0], rd_data[1], rd_data[2], rd_resp[5:0]);
      else n_pass++;
      wr_data[0] = 32'h1; wr_data[1] = 32'h2; wr_data[2] = 32'h3;
      do_write(1'b0, 32'h90, 8'd1, 2'b01, 3, 2, 4'hF);
      n_total++;
      if (g_bresp !== 2'b10) $display("FAIL late_wlast_bresp: got %b expected 10", g_bresp);
      else n_pass++;
      ar_phase(1'b0, 32'h04, 8'd2, 2'b10);
      r_phase(3, 1'b0);
      n_total++;
      if ({rd_data[0], rd_data[1], rd_data[2]} !== {pat_word(1), pat_word(2), pat_word(3)})
         $display("FAIL badwrap_data: got %h %h %h expected %h %h %h", rd_data[0], rd_data[1], rd_data[2],
                  pat_word(1), pat_word(2), pat_word(3));
      else n_pass++;
      n_total++;
      if ({rd_resp[5:0], rd_last[2:0]} !== {6'b101010, 3'b100})
         $display("FAIL badwrap_resp: got resp=%b last=%b expected 101010 100", rd_resp[5:0], rd_last[2:0]);
      else n_pass++;
      ar_phase(1'b0, 32'h0, 8'd0, 2'b11);
      r_phase(1, 1'b0);
      n_total++;
      if ({timeout, rd_resp[1:0], rd_data[0]} !== {1'b0, 2'b10, pat_word(0)})
         $display("FAIL burst11_read: got to=%b resp=%b data=%h expected 0 10 ffffffff",
                  timeout, rd_resp[1:0], rd_data[0]);
      else n_pass++;
   endtask

   task automatic test_conflict();
      timeout = 1'b0;
      ARID = 1'b1; ARADDR = 32'h60; ARLEN = 8'd0; ARBURST = 2'b01; ARVALID = 1'b1;
      wr_data[0] = 32'hCAFEF00D;
      aw_phase(1'b0, 32'h60, 8'd0, 2'b01);
      n_total++;
      if (g_ar_at_aw !== 1'b0) $display("FAIL conflict_arready: got %b expected 0", g_ar_at_aw);
      else n_pass++;
      w_phase(1, 0, 4'hF);
      b_phase();
      n_total++;
      if ({g_bid, g_bresp} !== 3'b000)
         $display("FAIL conflict_b: got bid=%b bresp=%b expected bid=0 bresp=00", g_bid, g_bresp);
      else n_pass++;
      ar_phase(1'b1, 32'h60, 8'd0, 2'b01);
      r_phase(1, 1'b0);
      n_total++;
      if ({timeout, rd_data[0], rd_id, rd_last[0]} !== {1'b0, 32'hCAFEF00D, 1'b1, 1'b1})
         $display("FAIL conflict_read: got to=%b data=%h rid=%b last=%b expected 0 cafef00d 1 1",
                  timeout, rd_data[0], rd_id, rd_last[0]);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      timeout = 1'b0;
      ar_phase(1'b0, 32'h0, 8'd3, 2'b01);
      r_phase(4, 1'b1);
      n_total++;
      if (stall_err !== 0) $display("FAIL stall_stable: got %0d changes expected 0", stall_err);
      else n_pass++;
      n_total++;
      if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {pat_word(0), pat_word(1), pat_word(2), pat_word(3)})
         $display("FAIL stall_data: got %h %h %h %h", rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
      else n_pass++;
      n_total++;
      if ({timeout, rd_last[3:0], rd_cycles} !== {1'b0, 4'b1000, 32'sd8})
         $display("FAIL stall_ctrl: got to=%b last=%b cycles=%0d expected 0 1000 8", timeout, rd_last[3:0], rd_cycles);
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      timeout = 1'b0;
      ar_phase(1'b1, 32'h10, 8'd7, 2'b01);
      r_phase(2, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_total++;
      if ({RVALID, RLAST, RDATA} !== 34'd0)
         $display("FAIL midread_reset: got rvalid=%b rlast=%b rdata=%h expected 0 0 0", RVALID, RLAST, RDATA);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({AWREADY, ARREADY, RVALID} !== 3'b110)
         $display("FAIL midread_idle: got %b expected 110", {AWREADY, ARREADY, RVALID});
      else n_pass++;
      @(posedge clk); #1;
      ar_phase(1'b0, 32'h10, 8'd1, 2'b01);
      r_phase(2, 1'b0);
      n_total++;
      if ({timeout, rd_data[0], rd_data[1], rd_last[1:0], rd_resp[3:0]} !==
          {1'b0, pat_word(4), pat_word(5), 2'b10, 4'd0})
         $display("FAIL after_reset_read: got to=%b %h %h last=%b resp=%h", timeout, rd_data[0], rd_data[1],
                  rd_last[1:0], rd_resp[3:0]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_incr();
      test_wrap();
      test_strobe();
      test_slverr();
      test_conflict();
      test_backpressure();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
